// File: rtl/padctrl_seq_pkg.sv
// padctrl_seq_pkg: register offsets, field layout, reset values and sequencer
// state encoding shared by the pad-control sequencer files.
package padctrl_seq_pkg;

    // Byte offsets within the APB window
    localparam logic [19:0] A_BANK   = 20'h000;  // + 4*b
    localparam logic [19:0] A_PU     = 20'h040;
    localparam logic [19:0] A_PD     = 20'h044;
    localparam logic [19:0] A_CTRL   = 20'h080;
    localparam logic [19:0] A_LOCK   = 20'h084;
    localparam logic [19:0] A_ACT    = 20'h100;  // + 4*b
    localparam logic [19:0] A_ACT_PU = 20'h140;
    localparam logic [19:0] A_ACT_PD = 20'h144;

    // CTRL bit positions
    localparam int CTRL_COMMIT  = 0;   // write
    localparam int CTRL_BUSY    = 0;   // read
    localparam int CTRL_PENDING = 1;   // read

    // One bank's pad-group control, laid out as in the BANK/ACT registers
    typedef struct packed {
        logic       schmitt;  // [3]
        logic       slew;     // [2]
        logic [1:0] drive;    // [1:0]
    } bank_cfg_t;

    localparam bank_cfg_t BANK_RST = '{schmitt: 1'b1, slew: 1'b0, drive: 2'b01};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        FINISH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/falsepath_anchor.sv
// falsepath_anchor: named pass-through cell marking the boundary of every
// pad-control output so timing constraints can target it.
//   d : input vector
//   q : identical output vector
module falsepath_anchor #(
    parameter int W = 1
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    assign q = d;
endmodule

// File: rtl/padctrl_seq_ramp.sv
// padctrl_seq_ramp: one drive-code stepper. Moves the current code one step
// toward the target; shared across banks by the sequencer's bank mux.
//   cur  : current active drive code
//   tgt  : target drive code
//   nxt  : code after one step (equals cur when already at target)
//   done : cur already equals tgt
module padctrl_seq_ramp (
    input  logic [1:0] cur,
    input  logic [1:0] tgt,
    output logic [1:0] nxt,
    output logic       done
);
    always_comb begin
        nxt  = cur;
        done = (cur == tgt);
        if (cur < tgt)      nxt = cur + 2'd1;
        else if (cur > tgt) nxt = cur - 2'd1;
    end
endmodule

// File: rtl/padctrl_seq.sv
// padctrl_seq: APB-programmed pad control. Shadow registers are captured to a
// target set on COMMIT; a sequencer then walks the banks, ramping each drive
// code one step every STEP_CYCLES and copying slew/schmitt, and finally applies
// the GPIO pulls. A COMMIT while busy is remembered and re-run after FINISH.
// Optional build macro PADCTRL_SEQ_LOCK_EN adds a sticky LOCK register at 0x084.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   apbs_*                  APB slave (pready tied 1, reads combinational)
//   bank_drive/slew/schmitt active per-bank pad controls
//   gpio_pu/gpio_pd         active GPIO pulls
module padctrl_seq
    import padctrl_seq_pkg::*;
#(
    parameter int N_BANKS     = 4,
    parameter int N_GPIO      = 6,
    parameter int STEP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   apbs_psel,
    input  logic                   apbs_penable,
    input  logic                   apbs_pwrite,
    input  logic [19:0]            apbs_paddr,
    input  logic [31:0]            apbs_pwdata,
    output logic [31:0]            apbs_prdata,
    output logic                   apbs_pready,
    output logic                   apbs_pslverr,
    output logic [2*N_BANKS-1:0]   bank_drive,
    output logic [N_BANKS-1:0]     bank_slew,
    output logic [N_BANKS-1:0]     bank_schmitt,
    output logic [N_GPIO-1:0]      gpio_pu,
    output logic [N_GPIO-1:0]      gpio_pd
);
    localparam int BW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int TW = $clog2(STEP_CYCLES + 1);
    localparam logic [BW-1:0] B_LAST   = BW'(N_BANKS - 1);
    localparam logic [TW-1:0] T_RELOAD = TW'(STEP_CYCLES - 1);

    bank_cfg_t [N_BANKS-1:0] shadow_bank, target_bank, act_bank;
    logic [N_GPIO-1:0] shadow_pu, shadow_pd, target_pu, target_pd, act_pu, act_pd;

    seq_state_t    state, state_n;
    logic [BW-1:0] b, b_n;
    logic [TW-1:0] timer, timer_n;
    logic          pending, pending_n;
    logic          load_target, step_bank, apply_pulls;
    logic          locked;

    // ---------------- APB decode ----------------
    logic        access, wr_ok, err;
    logic [19:0] addr;
    logic [3:0]  sel;
    logic hit_bank, hit_pu, hit_pd, hit_ctrl, hit_lock;
    logic hit_act, hit_act_pu, hit_act_pd, hit_rw, hit_ro, commit;
    logic [31:0] rdata;

    assign access = apbs_psel & apbs_penable;
    assign addr   = {apbs_paddr[19:2], 2'b00};
    assign sel    = addr[5:2];

    assign hit_bank   = (addr[19:6] == A_BANK[19:6]) && (int'(sel) < N_BANKS);
    assign hit_act    = (addr[19:6] == A_ACT[19:6])  && (int'(sel) < N_BANKS);
    assign hit_pu     = (addr == A_PU);
    assign hit_pd     = (addr == A_PD);
    assign hit_ctrl   = (addr == A_CTRL);
    assign hit_act_pu = (addr == A_ACT_PU);
    assign hit_act_pd = (addr == A_ACT_PD);

`ifdef PADCTRL_SEQ_LOCK_EN
    assign hit_lock = (addr == A_LOCK);
    always_ff @(posedge clk) begin
        if (!rst_n)                                      locked <= 1'b0;
        else if (wr_ok && hit_lock && apbs_pwdata[0])    locked <= 1'b1;
    end
`else
    assign hit_lock = 1'b0;
    assign locked   = 1'b0;
`endif

    assign hit_rw = hit_bank | hit_pu | hit_pd | hit_ctrl | hit_lock;
    assign hit_ro = hit_act | hit_act_pu | hit_act_pd;
    // Lock protects everything writable except LOCK itself
    assign err    = access & (~(hit_rw | hit_ro)
                            | (apbs_pwrite & hit_ro)
                            | (apbs_pwrite & locked & (hit_rw & ~hit_lock)));
    assign wr_ok  = access & apbs_pwrite & ~err;
    assign commit = wr_ok & hit_ctrl & apbs_pwdata[CTRL_COMMIT];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            if (hit_bank && sel == 4'(i)) rdata[3:0] = shadow_bank[i];
            if (hit_act  && sel == 4'(i)) rdata[3:0] = act_bank[i];
        end
        if (hit_pu)     rdata[N_GPIO-1:0] = shadow_pu;
        if (hit_pd)     rdata[N_GPIO-1:0] = shadow_pd;
        if (hit_act_pu) rdata[N_GPIO-1:0] = act_pu;
        if (hit_act_pd) rdata[N_GPIO-1:0] = act_pd;
        if (hit_ctrl) begin
            rdata[CTRL_BUSY]    = (state != IDLE);
            rdata[CTRL_PENDING] = pending;
        end
        if (hit_lock) rdata[0] = locked;
    end

    logic unused_bits;
    assign unused_bits = ^{apbs_paddr[1:0], apbs_pwdata};

    // ---------------- ramp stepper on the selected bank ----------------
    logic [1:0] ramp_nxt;
    logic       ramp_done;

    padctrl_seq_ramp u_ramp (
        .cur  (act_bank[b].drive),
        .tgt  (target_bank[b].drive),
        .nxt  (ramp_nxt),
        .done (ramp_done)
    );

    // ---------------- sequencer FSM ----------------
    always_comb begin
        state_n     = state;
        b_n         = b;
        timer_n     = timer;
        pending_n   = pending;
        load_target = 1'b0;
        step_bank   = 1'b0;
        apply_pulls = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    load_target = 1'b1;
                    state_n     = APPLY;
                    b_n         = '0;
                    timer_n     = '0;
                end
            end
            APPLY: begin
                if (commit) pending_n = 1'b1;
                if (timer != '0) begin
                    timer_n = timer - TW'(1);
                end else begin
                    step_bank = 1'b1;
                    if (!ramp_done)      timer_n = T_RELOAD;
                    else if (b == B_LAST) state_n = FINISH;
                    else                  b_n     = b + BW'(1);
                end
            end
            FINISH: begin
                apply_pulls = 1'b1;
                // A COMMIT landing in FINISH is served as if already pending
                if (pending || commit) begin
                    pending_n   = 1'b0;
                    load_target = 1'b1;
                    state_n     = APPLY;
                    b_n         = '0;
                    timer_n     = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- state and register file ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            b           <= '0;
            timer       <= '0;
            pending     <= 1'b0;
            shadow_bank <= {N_BANKS{BANK_RST}};
            target_bank <= {N_BANKS{BANK_RST}};
            act_bank    <= {N_BANKS{BANK_RST}};
            shadow_pu   <= '0;
            shadow_pd   <= '0;
            target_pu   <= '0;
            target_pd   <= '0;
            act_pu      <= '0;
            act_pd      <= '0;
        end else begin
            state   <= state_n;
            b       <= b_n;
            timer   <= timer_n;
            pending <= pending_n;

            if (wr_ok) begin
                for (int i = 0; i < N_BANKS; i++)
                    if (hit_bank && sel == 4'(i)) shadow_bank[i] <= apbs_pwdata[3:0];
                if (hit_pu) shadow_pu <= apbs_pwdata[N_GPIO-1:0];
                if (hit_pd) shadow_pd <= apbs_pwdata[N_GPIO-1:0];
            end

            if (load_target) begin
                target_bank <= shadow_bank;
                target_pu   <= shadow_pu;
                target_pd   <= shadow_pd & ~shadow_pu;  // pull-up wins a conflict
            end

            if (step_bank) begin
                act_bank[b].drive   <= ramp_nxt;
                act_bank[b].slew    <= target_bank[b].slew;
                act_bank[b].schmitt <= target_bank[b].schmitt;
            end

            if (apply_pulls) begin
                act_pu <= target_pu;
                act_pd <= target_pd;
            end
        end
    end

    // ---------------- outputs ----------------
    logic [2*N_BANKS-1:0] drive_w;
    logic [N_BANKS-1:0]   slew_w, schmitt_w;

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        assign drive_w[2*g +: 2] = act_bank[g].drive;
        assign slew_w[g]         = act_bank[g].slew;
        assign schmitt_w[g]      = act_bank[g].schmitt;
    end

    falsepath_anchor #(.W(32))        u_fa_prdata  (.d((access & ~apbs_pwrite) ? rdata : 32'd0), .q(apbs_prdata));
    falsepath_anchor #(.W(1))         u_fa_pready  (.d(1'b1),     .q(apbs_pready));
    falsepath_anchor #(.W(1))         u_fa_pslverr (.d(err),      .q(apbs_pslverr));
    falsepath_anchor #(.W(2*N_BANKS)) u_fa_drive   (.d(drive_w),  .q(bank_drive));
    falsepath_anchor #(.W(N_BANKS))   u_fa_slew    (.d(slew_w),   .q(bank_slew));
    falsepath_anchor #(.W(N_BANKS))   u_fa_schmitt (.d(schmitt_w), .q(bank_schmitt));
    falsepath_anchor #(.W(N_GPIO))    u_fa_pu      (.d(act_pu),   .q(gpio_pu));
    falsepath_anchor #(.W(N_GPIO))    u_fa_pd      (.d(act_pd),   .q(gpio_pd));

endmodule

// File: tb/tb_padctrl_seq.sv
// tb_padctrl_seq: directed scoreboard bench for padctrl_seq (4 banks, 6 GPIO,
// 4-cycle ramp spacing). APB expectations and drive-code transitions are
// queued by the stimulus and consumed by independent monitors.
module tb_padctrl_seq;
    localparam int NB = 4;
    localparam int NG = 6;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [19:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic pready, pslverr;
    logic [2*NB-1:0] bank_drive;
    logic [NB-1:0] bank_slew, bank_schmitt;
    logic [NG-1:0] gpio_pu, gpio_pd;

    padctrl_seq #(.N_BANKS(NB), .N_GPIO(NG), .STEP_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata), .apbs_prdata(prdata),
        .apbs_pready(pready), .apbs_pslverr(pslverr),
        .bank_drive(bank_drive), .bank_slew(bank_slew), .bank_schmitt(bank_schmitt),
        .gpio_pu(gpio_pu), .gpio_pd(gpio_pd)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
    } apb_exp_t;

    typedef struct {
        logic [7:0] val;
        int         gap;   // cycles since previous change, 0 = don't care
    } drv_exp_t;

    apb_exp_t apb_q[$];
    drv_exp_t drv_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // APB monitor: every access phase consumes one expectation
    always @(negedge clk) begin
        if (psel && penable) begin
            if (apb_q.size() == 0) begin
                check("apb_unexpected_access", 32'd1, 32'd0);
            end else begin
                apb_exp_t e;
                e = apb_q.pop_front();
                check({e.name, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
                check({e.name, "_pready"}, {31'd0, pready}, 32'd1);
                if (e.chk_data) check({e.name, "_prdata"}, prdata, e.data);
            end
        end
    end

    // Drive monitor: every change of bank_drive consumes one expectation
    logic       mon_en = 1'b0;
    logic [7:0] last_drive;
    int         last_cyc;
    always @(negedge clk) begin
        if (mon_en && bank_drive !== last_drive) begin
            if (drv_q.size() == 0) begin
                check("drive_unexpected_change", {24'd0, bank_drive}, {24'd0, last_drive});
            end else begin
                drv_exp_t d;
                d = drv_q.pop_front();
                check("drive_value", {24'd0, bank_drive}, {24'd0, d.val});
                if (d.gap != 0) check("drive_step_gap", cyc - last_cyc, d.gap);
            end
            last_drive = bank_drive;
            last_cyc   = cyc;
        end
    end

    task automatic apb(input logic wr, input logic [19:0] a, input logic [31:0] wd,
                       input string name, input logic chk, input logic [31:0] exp, input logic e_err);
        apb_exp_t e;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        e.name = name; e.data = exp; e.chk_data = chk; e.err = e_err;
        apb_q.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [19:0] a, input logic [31:0] d, input string n, input logic e_err);
        apb(1'b1, a, d, n, 1'b0, 32'd0, e_err);
    endtask

    task automatic rd(input logic [19:0] a, input string n, input logic [31:0] exp);
        apb(1'b0, a, 32'd0, n, 1'b1, exp, 1'b0);
    endtask

    task automatic push_drv(input logic [7:0] v, input int gap);
        drv_exp_t d;
        d.val = v; d.gap = gap;
        drv_q.push_back(d);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(1);
        last_drive = bank_drive;
        last_cyc   = cyc;
        mon_en     = 1'b1;
        check("rst_drive",   {24'd0, bank_drive},   32'h55);
        check("rst_slew",    {28'd0, bank_slew},    32'h0);
        check("rst_schmitt", {28'd0, bank_schmitt}, 32'hF);
        check("rst_pu",      {26'd0, gpio_pu},      32'h0);
        check("rst_pd",      {26'd0, gpio_pd},      32'h0);
        rd(20'h080, "rst_ctrl", 32'h0);
        rd(20'h000, "rst_bank0", 32'h9);

        // ---- bank0 ramp 1 -> 2 -> 3, 4 cycles apart ----
        push_drv(8'h56, 0);
        push_drv(8'h57, SC);
        wr(20'h000, 32'h3, "wr_bank0", 1'b0);
        wr(20'h080, 32'h1, "commit1", 1'b0);
        rd(20'h080, "ctrl_busy1", 32'h1);
        wait_cyc(40);
        rd(20'h080, "ctrl_idle1", 32'h0);
        rd(20'h100, "act0", 32'h3);
        check("schmitt_after1", {28'd0, bank_schmitt}, 32'hE);

        // ---- pulls with conflict ----
        wr(20'h040, 32'h05, "wr_pu", 1'b0);
        wr(20'h044, 32'h07, "wr_pd", 1'b0);
        wr(20'h080, 32'h1, "commit2", 1'b0);
        wait_cyc(20);
        rd(20'h140, "act_pu", 32'h05);
        rd(20'h144, "act_pd", 32'h02);
        check("gpio_pu", {26'd0, gpio_pu}, 32'h05);
        check("gpio_pd", {26'd0, gpio_pd}, 32'h02);

        // ---- commit during APPLY sets pending, second pass ramps bank3 ----
        wr(20'h004, 32'h3, "wr_bank1", 1'b0);
        wr(20'h008, 32'h3, "wr_bank2", 1'b0);
        push_drv(8'h5B, 0);
        push_drv(8'h5F, 4);
        push_drv(8'h6F, 5);
        push_drv(8'h7F, 4);
        push_drv(8'h3F, 10);
        wr(20'h080, 32'h1, "commit3", 1'b0);
        wr(20'h00C, 32'h0, "wr_bank3", 1'b0);
        wr(20'h080, 32'h1, "commit4", 1'b0);
        rd(20'h080, "ctrl_pending", 32'h3);
        wait_cyc(60);
        rd(20'h080, "ctrl_idle2", 32'h0);
        rd(20'h10C, "act3", 32'h0);
        check("schmitt_after3", {28'd0, bank_schmitt}, 32'h0);

        // ---- error responses ----
        apb(1'b0, 20'h0C0, 32'd0, "rd_unmapped", 1'b0, 32'd0, 1'b1);
        wr(20'h104, 32'h0, "wr_act1", 1'b1);
        rd(20'h104, "act1_kept", 32'h3);
`ifndef PADCTRL_SEQ_LOCK_EN
        wr(20'h084, 32'h1, "wr_nolock", 1'b1);
`endif

        // ---- reset mid-ramp ----
        push_drv(8'h3E, 0);
        push_drv(8'h55, 0);
        wr(20'h000, 32'h0, "wr_bank0_down", 1'b0);
        wr(20'h080, 32'h1, "commit5", 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        wait_cyc(1);
        check("midrst_drive",   {24'd0, bank_drive},   32'h55);
        check("midrst_schmitt", {28'd0, bank_schmitt}, 32'hF);
        check("midrst_pu",      {26'd0, gpio_pu},      32'h0);
        check("midrst_pd",      {26'd0, gpio_pd},      32'h0);
        rst_n = 1'b1;
        rd(20'h080, "midrst_ctrl", 32'h0);
        rd(20'h000, "midrst_bank0", 32'h9);

`ifdef PADCTRL_SEQ_LOCK_EN
        // ---- lock ----
        wr(20'h084, 32'h1, "wr_lock", 1'b0);
        rd(20'h084, "lock_set", 32'h1);
        wr(20'h000, 32'h2, "wr_bank0_locked", 1'b1);
        wr(20'h080, 32'h1, "commit_locked", 1'b1);
        rd(20'h000, "bank0_locked", 32'h9);
        rd(20'h080, "ctrl_locked", 32'h0);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        rd(20'h084, "lock_cleared", 32'h0);
`endif

        wait_cyc(5);
        check("apb_q_drained", apb_q.size(), 32'd0);
        check("drv_q_drained", drv_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule
